// File: rtl/store_pkg.sv
// Shared encodings and payload type for the store narrowing path.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_wr_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane replication, byte-enable generation and alignment check
// for little-endian byte/halfword/word stores.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic              illegal
);

  always_comb begin
    wdata   = '0;
    be      = '0;
    illegal = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'(4'b0001 << addr);
      end
      SZ_HALF: begin
        wdata   = {2{data[15:0]}};
        be      = addr[1] ? 4'b1100 : 4'b0011;
        illegal = addr[0];
      end
      SZ_WORD: begin
        wdata   = data;
        be      = 4'b1111;
        illegal = (addr != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Accepts one SB/SH/SW request, holds an aligned write on the data-memory port
// until acknowledged, and rejects misaligned or reserved-size stores.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              st_done,
  output logic              st_err
);

  state_e            state_q, state_d;
  mem_wr_t           pack_c;
  logic              illegal_c;
  logic              ready_d, req_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [BE_W-1:0]   be_d;

  store_lane_pack u_pack (
    .size    (st_size),
    .addr    (st_addr[1:0]),
    .data    (st_data),
    .wdata   (pack_c.wdata),
    .be      (pack_c.be),
    .illegal (illegal_c)
  );

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      st_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_ready  <= ready_d;
      mem_req   <= req_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      st_done   <= done_d;
      st_err    <= err_d;
    end
  end

  // Next state and next output values; memory fields hold unless a legal accept
  always_comb begin
    state_d = state_q;
    ready_d = st_ready;
    req_d   = mem_req;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    be_d    = mem_be;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        req_d   = 1'b0;
        if (st_valid && st_ready) begin
          if (illegal_c) begin
            err_d = 1'b1;
          end else begin
            state_d = REQ;
            ready_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
            wdata_d = pack_c.wdata;
            be_d    = pack_c.be;
          end
        end
      end
      REQ: begin
        ready_d = 1'b0;
        req_d   = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
          ready_d = 1'b1;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        req_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench: directed cases plus randomized stores compared against
// a lane-arithmetic reference model.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Last values the memory port is expected to hold
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be    = '0;

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .st_done   (st_done),
    .st_err    (st_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: lane i carries data byte (i mod nbytes); enabled lanes are the
  // nbytes lanes starting at the address offset.
  function automatic void ref_store(input logic [1:0] sz, input logic [31:0] addr,
                                    input logic [31:0] d, output logic ill,
                                    output logic [31:0] wd, output logic [3:0] be);
    int nb;
    int off;
    nb  = (sz == 2'd3) ? 4 : (1 << sz);
    off = int'(addr[1:0]);
    ill = (sz == 2'd3) || ((off % nb) != 0);
    wd  = '0;
    be  = '0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % nb) +: 8];
      be[i]        = (i >= off) && (i < off + nb);
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".req"},   64'(mem_req),   64'd0);
    check({tag, ".ready"}, 64'(st_ready),  64'd1);
    check({tag, ".addr"},  64'(mem_addr),  64'(exp_addr));
    check({tag, ".wdata"}, 64'(mem_wdata), 64'(exp_wdata));
    check({tag, ".be"},    64'(mem_be),    64'(exp_be));
  endtask

  // Issue one store at a negedge; ack after ack_delay extra REQ cycles.
  // Returns at the negedge where the completion/error is visible.
  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] d, input int ack_delay);
    logic        ill;
    logic [31:0] wd;
    logic [3:0]  be;
    ref_store(sz, addr, d, ill, wd, be);
    check({tag, ".ready_in"}, 64'(st_ready), 64'd1);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = addr;
    st_data  = d;
    @(negedge clk);
    st_valid = 1'b0;
    st_size  = 2'($urandom);
    st_addr  = $urandom;
    st_data  = $urandom;
    if (ill) begin
      check({tag, ".err"},  64'(st_err),  64'd1);
      check({tag, ".done"}, 64'(st_done), 64'd0);
      check_idle(tag);
    end else begin
      exp_addr  = {addr[31:2], 2'b00};
      exp_wdata = wd;
      exp_be    = be;
      for (int k = 0; k <= ack_delay; k++) begin
        check({tag, ".req"},   64'(mem_req),   64'd1);
        check({tag, ".ready"}, 64'(st_ready),  64'd0);
        check({tag, ".addr"},  64'(mem_addr),  64'(exp_addr));
        check({tag, ".wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        check({tag, ".be"},    64'(mem_be),    64'(exp_be));
        check({tag, ".done0"}, 64'(st_done),   64'd0);
        check({tag, ".err0"},  64'(st_err),    64'd0);
        mem_ack = (k == ack_delay);
        @(negedge clk);
        mem_ack = 1'b0;
      end
      check({tag, ".done"}, 64'(st_done), 64'd1);
      check({tag, ".err"},  64'(st_err),  64'd0);
      check_idle(tag);
    end
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_size  = 2'd0;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check("reset.done", 64'(st_done), 64'd0);
    check("reset.err",  64'(st_err),  64'd0);

    // Ack while idle has no effect
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_idle("idle_ack");
    check("idle_ack.done", 64'(st_done), 64'd0);

    do_store("sb_1003", 2'b00, 32'h1003, 32'hAABBCCDD, 0);
    check("sb_1003.wd", 64'(mem_wdata), 64'hDDDDDDDD);
    check("sb_1003.be", 64'(mem_be), 64'b1000);
    do_store("sh_2002", 2'b01, 32'h2002, 32'h12345678, 1);
    check("sh_2002.wd", 64'(mem_wdata), 64'h56785678);
    do_store("sh_2001", 2'b01, 32'h2001, 32'h12345678, 0);
    do_store("sw_3004", 2'b10, 32'h3004, 32'hCAFEF00D, 5);
    @(negedge clk);
    check("sw_3004.done_end", 64'(st_done), 64'd0);
    do_store("sw_3006", 2'b10, 32'h3006, 32'h11111111, 0);
    do_store("rsvd",    2'b11, 32'h3000, 32'h22222222, 0);

    // Reset during the second REQ cycle abandons the write
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h4000; st_data = 32'h0BADF00D;
    @(negedge clk);
    st_valid = 1'b0;
    check("rst_req.req1", 64'(mem_req), 64'd1);
    @(negedge clk);
    check("rst_req.req2", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0;
    check_idle("rst_req");
    check("rst_req.done", 64'(st_done), 64'd0);
    @(negedge clk);
    check("rst_req.done2", 64'(st_done), 64'd0);
    do_store("sb_0", 2'b00, 32'h0, 32'h000000A5, 0);
    check("sb_0.be", 64'(mem_be), 64'b0001);

    // Back-to-back with immediate ack
    do_store("b2b_0", 2'b00, 32'h0, 32'h00000011, 0);
    do_store("b2b_1", 2'b00, 32'h1, 32'h00000022, 0);
    check("b2b_1.be", 64'(mem_be), 64'b0010);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_store("rand", 2'($urandom_range(0, 3)), a, $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
